csr_ram_sequencer: RTL and testbench

- Phase sequencer and port-A arbiter for the three CSR block RAMs: value, column and row-pointer.
- It runs the CSR loader (writes), then the SpMV engine (reads), and lets a low-priority host readback port share the RAMs.
- It routes one shared port-A bus to all three RAMs and returns read data with a tag after a fixed latency.
- It replaces ad-hoc done-based muxing with explicit phases, drain, and grant handshakes.

---
 rtl/csr_ram_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_csr_ram_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_ram_sequencer.sv
// Phase sequencer and shared port-A arbiter for the CSR value/column/row-pointer RAMs.
// Optional host starvation guard is enabled by defining CSR_HR_STARVE_GUARD_EN.
module csr_ram_sequencer #(
  parameter int ADDR_W       = 14,
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [1:0]        ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  input  logic              mv_req,
  input  logic [1:0]        mv_sel,
  input  logic [ADDR_W-1:0] mv_addr,
  input  logic              mv_done,
  output logic              mv_gnt,
  output logic              mv_start,
  input  logic              hr_req,
  input  logic [1:0]        hr_sel,
  input  logic [ADDR_W-1:0] hr_addr,
  output logic              hr_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we_val,
  output logic              ram_we_col,
  output logic              ram_we_row,
  input  logic [DATA_W-1:0] dout_val,
  input  logic [DATA_W-1:0] dout_col,
  input  logic [DATA_W-1:0] dout_row,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [1:0]        rtag,
  output logic [2:0]        phase,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_COMPUTE = 3'd2, S_DRAIN = 3'd3, S_FINISH = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              first_q;
  logic              hr_force;
  logic              drain_done;
  logic              push_vld;
  logic [1:0]        push_sel, push_tag;
  logic [RD_LAT-1:0]      vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][1:0] sel_pipe_q, sel_pipe_d;
  logic [RD_LAT-1:0][1:0] tag_pipe_q, tag_pipe_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start)      state_d = S_LOAD;
      S_LOAD:    if (ld_done)    state_d = S_COMPUTE;
      S_COMPUTE: if (mv_done)    state_d = S_DRAIN;
      S_DRAIN:   if (drain_done) state_d = S_FINISH;
      S_FINISH:  if (start)      state_d = S_LOAD;
      default:                   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_gnt = 1'b0;
    mv_gnt = 1'b0;
    hr_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE, S_FINISH: hr_gnt = hr_req;
        S_LOAD:           ld_gnt = ld_req;
        S_COMPUTE: begin
          if (hr_force) begin
            hr_gnt = 1'b1;
          end else begin
            mv_gnt = mv_req;
            hr_gnt = hr_req & ~mv_req;
          end
        end
        default: ;
      endcase
    end
  end

  assign mv_start = (state_q == S_COMPUTE) & first_q;
  assign phase    = state_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done     = (state_q == S_FINISH);

`ifdef CSR_HR_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  assign hr_force = hr_req && (state_q == S_COMPUTE) && (starve_q >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (hr_gnt)
      starve_d = '0;
    else if (hr_req && (state_q == S_COMPUTE))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign hr_force = 1'b0;
`endif

  // Shared port-A bus: only the loader ever drives write data or write enables.
  always_comb begin
    ram_addr   = '0;
    ram_din    = '0;
    ram_we_val = 1'b0;
    ram_we_col = 1'b0;
    ram_we_row = 1'b0;
    push_vld   = 1'b0;
    push_sel   = 2'd0;
    push_tag   = 2'd0;
    if (ld_gnt) begin
      ram_addr   = ld_addr;
      ram_din    = ld_wdata;
      ram_we_val = ld_we & (ld_sel == 2'd0);
      ram_we_col = ld_we & (ld_sel == 2'd1);
      ram_we_row = ld_we & (ld_sel == 2'd2);
      push_vld   = ~ld_we;
      push_sel   = ld_sel;
      push_tag   = 2'd0;
    end else if (mv_gnt) begin
      ram_addr = mv_addr;
      push_vld = 1'b1;
      push_sel = mv_sel;
      push_tag = 2'd1;
    end else if (hr_gnt) begin
      ram_addr = hr_addr;
      push_vld = 1'b1;
      push_sel = hr_sel;
      push_tag = 2'd2;
    end
  end

  always_comb begin
    vld_pipe_d    = '0;
    sel_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[0] = push_vld;
    sel_pipe_d[0] = push_sel;
    tag_pipe_d[0] = push_tag;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      sel_pipe_d[i] = sel_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  // Leave DRAIN in the cycle the last in-flight read is presented.
  assign drain_done = ~|vld_pipe_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      sel_pipe_q <= '0;
      tag_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      sel_pipe_q <= sel_pipe_d;
      tag_pipe_q <= tag_pipe_d;
    end
  end

  assign rvalid = vld_pipe_q[RD_LAT-1];
  assign rtag   = rvalid ? tag_pipe_q[RD_LAT-1] : 2'd0;

  always_comb begin
    rdata = '0;
    if (rvalid) begin
      case (sel_pipe_q[RD_LAT-1])
        2'd0:    rdata = dout_val;
        2'd1:    rdata = dout_col;
        2'd2:    rdata = dout_row;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ram_sequencer.sv
// Directed bench for csr_ram_sequencer with RD_LAT=3 and a behavioural 3-RAM model.
module tb_csr_ram_sequencer;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int LAT    = 3;
`ifdef CSR_HR_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, ld_req, ld_we, ld_done, mv_req, mv_done, hr_req;
  logic [1:0] ld_sel, mv_sel, hr_sel;
  logic [ADDR_W-1:0] ld_addr, mv_addr, hr_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic ld_gnt, mv_gnt, hr_gnt, mv_start, rvalid, busy, done;
  logic ram_we_val, ram_we_col, ram_we_row;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, dout_val, dout_col, dout_row, rdata;
  logic [1:0] rtag;
  logic [2:0] phase;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  csr_ram_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_req(ld_req), .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_done(ld_done), .ld_gnt(ld_gnt),
    .mv_req(mv_req), .mv_sel(mv_sel), .mv_addr(mv_addr), .mv_done(mv_done), .mv_gnt(mv_gnt),
    .mv_start(mv_start),
    .hr_req(hr_req), .hr_sel(hr_sel), .hr_addr(hr_addr), .hr_gnt(hr_gnt),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we_val(ram_we_val), .ram_we_col(ram_we_col), .ram_we_row(ram_we_row),
    .dout_val(dout_val), .dout_col(dout_col), .dout_row(dout_row),
    .rdata(rdata), .rvalid(rvalid), .rtag(rtag), .phase(phase), .busy(busy), .done(done)
  );

  // RAM model: write on clock, read data delayed LAT cycles.
  logic [DATA_W-1:0] m_val [1024];
  logic [DATA_W-1:0] m_col [1024];
  logic [DATA_W-1:0] m_row [1024];
  logic [DATA_W-1:0] p_val [LAT];
  logic [DATA_W-1:0] p_col [LAT];
  logic [DATA_W-1:0] p_row [LAT];

  always @(posedge clk) begin
    if (ram_we_val) m_val[ram_addr[9:0]] <= ram_din;
    if (ram_we_col) m_col[ram_addr[9:0]] <= ram_din;
    if (ram_we_row) m_row[ram_addr[9:0]] <= ram_din;
    p_val[0] <= m_val[ram_addr[9:0]];
    p_col[0] <= m_col[ram_addr[9:0]];
    p_row[0] <= m_row[ram_addr[9:0]];
    for (int i = 1; i < LAT; i++) begin
      p_val[i] <= p_val[i-1];
      p_col[i] <= p_col[i-1];
      p_row[i] <= p_row[i-1];
    end
  end
  assign dout_val = p_val[LAT-1];
  assign dout_col = p_col[LAT-1];
  assign dout_row = p_row[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_set(input logic req, input logic we, input logic [1:0] sel,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    ld_req = req; ld_we = we; ld_sel = sel; ld_addr = addr; ld_wdata = wd;
  endtask

  logic [31:0] exp_mv [3];
  logic        e_hr;

  initial begin
    exp_mv[0] = 32'hDEADBEEF; exp_mv[1] = 32'h3; exp_mv[2] = 32'h7;
    reset = 1'b1; start = 1'b0; ld_done = 1'b0; mv_done = 1'b0;
    ld_set(0, 0, 2'd0, '0, '0);
    mv_req = 1'b0; mv_sel = 2'd0; mv_addr = '0;
    hr_req = 1'b0; hr_sel = 2'd0; hr_addr = '0;
    repeat (2) tick();
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_flags", {busy, done, rvalid, mv_start}, 32'd0);
    chk("rst_bus", 32'(ram_addr), 32'd0);
    reset = 1'b0;
    tick();

    // IDLE: loader not grantable
    ld_set(1, 1, 2'd0, 14'd5, 32'h1);
    #1 chk("idle_ld_gnt", 32'(ld_gnt), 32'd0);
    chk("idle_no_we", {ram_we_val, ram_we_col, ram_we_row}, 32'd0);
    ld_set(0, 0, 2'd0, '0, '0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_phase", 32'(phase), 32'd1);
    chk("load_busy", {busy, done}, 32'b10);

    // LOAD: mv gated
    mv_req = 1'b1; mv_addr = 14'd9;
    #1 chk("load_mv_gnt", 32'(mv_gnt), 32'd0);
    chk("load_mv_bus", {ram_addr, ram_we_val, ram_we_col, ram_we_row}, 32'd0);
    mv_req = 1'b0;

    ld_set(1, 1, 2'd0, 14'd5, 32'hDEADBEEF);
    #1 chk("wr_val_gnt", 32'(ld_gnt), 32'd1);
    chk("wr_val_we", {ram_we_val, ram_we_col, ram_we_row}, 32'b100);
    chk("wr_val_din", ram_din, 32'hDEADBEEF);
    tick();
    ld_set(1, 1, 2'd1, 14'd5, 32'h3);
    #1 chk("wr_col_we", {ram_we_val, ram_we_col, ram_we_row}, 32'b010);
    tick();
    ld_set(1, 1, 2'd2, 14'd5, 32'h7);
    #1 chk("wr_row_we", {ram_we_val, ram_we_col, ram_we_row}, 32'b001);
    tick();
    ld_set(1, 1, 2'd2, 14'h3FF, 32'h55);
    #1 chk("row3ff_we", {ram_we_val, ram_we_col, ram_we_row}, 32'b001);
    chk("row3ff_addr", 32'(ram_addr), 32'h3FF);
    tick();
    ld_set(1, 1, 2'd3, 14'd5, 32'hFFFF);
    #1 chk("sel3_gnt", 32'(ld_gnt), 32'd1);
    chk("sel3_no_we", {ram_we_val, ram_we_col, ram_we_row}, 32'd0);
    tick();

    // loader readback, tag 0
    ld_set(1, 0, 2'd0, 14'd5, '0);
    #1 chk("ldrd_gnt", 32'(ld_gnt), 32'd1);
    chk("ldrd_no_we", {ram_we_val, ram_we_col, ram_we_row}, 32'd0);
    tick();
    ld_set(0, 0, 2'd0, '0, '0);
    tick();
    chk("ldrd_early", 32'(rvalid), 32'd0);
    tick();
    chk("ldrd_rvalid", {rvalid, rtag}, 32'b100);
    chk("ldrd_data", rdata, 32'hDEADBEEF);
    tick();
    chk("ldrd_single", 32'(rvalid), 32'd0);

    // request in the same cycle as ld_done is still granted
    ld_set(1, 1, 2'd1, 14'd6, 32'h9);
    ld_done = 1'b1;
    #1 chk("lddone_gnt", 32'(ld_gnt), 32'd1);
    tick();
    ld_set(0, 0, 2'd0, '0, '0);
    ld_done = 1'b0;
    chk("comp_phase", 32'(phase), 32'd2);
    chk("mv_start_1", 32'(mv_start), 32'd1);
    tick();
    chk("mv_start_0", 32'(mv_start), 32'd0);

    // COMPUTE: loader gated, start ignored
    ld_set(1, 1, 2'd0, 14'd5, 32'h1);
    start = 1'b1;
    #1 chk("comp_ld_gnt", 32'(ld_gnt), 32'd0);
    chk("comp_ld_bus", {ram_addr, ram_we_val, ram_we_col, ram_we_row}, 32'd0);
    tick();
    start = 1'b0;
    ld_set(0, 0, 2'd0, '0, '0);
    chk("start_ignored", 32'(phase), 32'd2);

    // SpMV reads sel 0,1,2 back-to-back
    for (int i = 0; i < 6; i++) begin
      mv_req = (i < 3); mv_sel = 2'(i % 3); mv_addr = 14'd5;
      #1;
      if (i < 3) chk($sformatf("mv_gnt%0d", i), 32'(mv_gnt), 32'd1);
      else begin
        chk($sformatf("mv_rv%0d", i - 3), {rvalid, rtag}, 32'b101);
        chk($sformatf("mv_rd%0d", i - 3), rdata, exp_mv[i-3]);
      end
      tick();
    end
    mv_req = 1'b0;
    chk("mv_rv_end", 32'(rvalid), 32'd0);

    // arbitration: both requesting for 20 cycles
    mv_req = 1'b1; mv_sel = 2'd0; mv_addr = 14'd5;
    hr_req = 1'b1; hr_sel = 2'd1; hr_addr = 14'd5;
    for (int c = 1; c <= 20; c++) begin
      e_hr = GUARD && (c == 9 || c == 18);
      #1 chk($sformatf("arb_hr%0d", c), 32'(hr_gnt), 32'(e_hr));
      chk($sformatf("arb_mv%0d", c), 32'(mv_gnt), 32'(!e_hr));
      tick();
    end
    mv_req = 1'b0; hr_req = 1'b0;
    repeat (LAT) tick();

    // drain: mv_done with a granted read
    mv_req = 1'b1; mv_sel = 2'd0; mv_addr = 14'd5; mv_done = 1'b1;
    #1 chk("drain_gnt", 32'(mv_gnt), 32'd1);
    tick();
    mv_req = 1'b0; mv_done = 1'b0;
    chk("drain_ph1", 32'(phase), 32'd3);
    mv_req = 1'b1; hr_req = 1'b1;
    #1 chk("drain_nogrant", {mv_gnt, hr_gnt, ld_gnt}, 32'd0);
    mv_req = 1'b0; hr_req = 1'b0;
    tick();
    chk("drain_ph2", 32'(phase), 32'd3);
    tick();
    chk("drain_ph3", 32'(phase), 32'd3);
    chk("drain_rv", {rvalid, rtag}, 32'b101);
    chk("drain_rd", rdata, 32'hDEADBEEF);
    tick();
    chk("finish_ph", 32'(phase), 32'd4);
    chk("finish_flags", {busy, done}, 32'b01);

    // FINISH: host readback, including sel=3
    hr_req = 1'b1; hr_sel = 2'd2; hr_addr = 14'd5;
    #1 chk("fin_hr_gnt", 32'(hr_gnt), 32'd1);
    tick();
    hr_sel = 2'd3;
    tick();
    hr_req = 1'b0;
    tick();
    chk("hr_rv", {rvalid, rtag}, 32'b110);
    chk("hr_rd", rdata, 32'h7);
    tick();
    chk("hr_rv3", {rvalid, rtag}, 32'b110);
    chk("hr_rd3", rdata, 32'h0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_ph", 32'(phase), 32'd1);
    chk("restart_done", 32'(done), 32'd0);

    // reset in the cycle after a granted read drops it
    ld_set(1, 0, 2'd0, 14'd5, '0);
    #1 chk("rst_rd_gnt", 32'(ld_gnt), 32'd1);
    tick();
    ld_set(0, 0, 2'd0, '0, '0);
    reset = 1'b1;
    tick();
    chk("rstmid_ph", 32'(phase), 32'd0);
    chk("rstmid_out", {rvalid, busy, done, mv_start, ld_gnt, mv_gnt, hr_gnt}, 32'd0);
    reset = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      chk($sformatf("rstmid_rv%0d", k), 32'(rvalid), 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
